// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM encoding and
// default geometry used by the top level, the bus interface and the read ports.
package reg_file_pkg;

  typedef logic [1:0] clr_state_t;

  localparam clr_state_t ST_IDLE  = 2'b00;
  localparam clr_state_t ST_CLEAR = 2'b01;
  localparam clr_state_t ST_DONE  = 2'b10;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 32;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: packed read ports, two write ports and the
// clear handshake. The slave side is the register file itself.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = $clog2(DEF_DEPTH),
  parameter int NUM_RD = 2
);

  logic [NUM_RD*AW-1:0] rd_addr_i;
  logic [NUM_RD*DW-1:0] rd_data_o;
  logic                 we0_i;
  logic [AW-1:0]        wa0_i;
  logic [DW-1:0]        wd0_i;
  logic                 we1_i;
  logic [AW-1:0]        wa1_i;
  logic [DW-1:0]        wd1_i;
  logic                 clr_req_i;
  logic                 clr_busy_o;
  logic                 clr_done_o;

  modport master (
    output rd_addr_i, we0_i, wa0_i, wd0_i, we1_i, wa1_i, wd1_i, clr_req_i,
    input  rd_data_o, clr_busy_o, clr_done_o
  );

  modport slave (
    input  rd_addr_i, we0_i, wa0_i, wd0_i, we1_i, wa1_i, wd1_i, clr_req_i,
    output rd_data_o, clr_busy_o, clr_done_o
  );

endinterface

// File: rtl/reg_file_mp_rdport.sv
// One combinational read port: stored word, optionally overridden by same-cycle
// write data (port 1 over port 0), with the zero register forced last.
module reg_file_mp_rdport
  import reg_file_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = $clog2(DEF_DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] stored_i,
  input  logic          byp_en_i,
  input  logic          we0_i,
  input  logic [AW-1:0] wa0_i,
  input  logic [DW-1:0] wd0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] wa1_i,
  input  logic [DW-1:0] wd1_i,
  output logic [DW-1:0] data_o
);

  always_comb begin
    data_o = stored_i;
    if (BYPASS && byp_en_i) begin
      if (we1_i && (wa1_i == addr_i)) begin
        data_o = wd1_i;
      end else if (we0_i && (wa0_i == addr_i)) begin
        data_o = wd0_i;
      end
    end
    if (ZERO_REG && (addr_i == '0)) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with prioritised dual write, optional
// zero register, write-to-read bypass and a one-entry-per-cycle clear sweep.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int              DW       = DEF_DW,
  parameter int              DEPTH    = DEF_DEPTH,
  parameter int              NUM_RD   = 2,
  parameter bit              ZERO_REG = 1'b1,
  parameter bit              BYPASS   = 1'b1,
  parameter int              INIT_IDX = 1,
  parameter logic [DW-1:0]   INIT_VAL = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  reg_file_mp_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  clr_state_t    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Port writes are open in IDLE and DONE; only the sweep blocks them.
  logic wr_open;
  logic we0_ok, we1_ok;

  assign wr_open = (state_q != ST_CLEAR);
  assign we0_ok  = wr_open && bus.we0_i && !(ZERO_REG && (bus.wa0_i == '0));
  assign we1_ok  = wr_open && bus.we1_i && !(ZERO_REG && (bus.wa1_i == '0));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
    done_d = (state_d == ST_DONE);
  end

  // Port 1 is applied after port 0 so it wins an address collision.
  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_CLEAR) begin
      mem_d[ptr_q] = '0;
    end else begin
      if (we0_ok) mem_d[bus.wa0_i] = bus.wd0_i;
      if (we1_ok) mem_d[bus.wa1_i] = bus.wd1_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i == INIT_IDX) ? INIT_VAL : '0;
      end
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.clr_busy_o = busy_q;
  assign bus.clr_done_o = done_q;

  logic [NUM_RD*DW-1:0] rd_data;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] data;

    assign addr = bus.rd_addr_i[k*AW +: AW];

    reg_file_mp_rdport #(
      .DW       (DW),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rdport (
      .addr_i   (addr),
      .stored_i (mem_q[addr]),
      .byp_en_i (wr_open),
      .we0_i    (we0_ok),
      .wa0_i    (bus.wa0_i),
      .wd0_i    (bus.wd0_i),
      .we1_i    (we1_ok),
      .wa1_i    (bus.wa1_i),
      .wd1_i    (bus.wd1_i),
      .data_o   (data)
    );

    assign rd_data[k*DW +: DW] = data;
  end

  assign bus.rd_data_o = rd_data;

endmodule
